// File: rtl/ff_bank_if.sv
// Interface bundle for the ff_bank flip-flop array: per-bit controls in,
// registered state and status out.
interface ff_bank_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             clr_err;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qc;
    logic [WIDTH-1:0] chg;
    logic             sr_err;

    modport master (
        output en, mode, j, k, clr_err,
        input  q, qc, chg, sr_err
    );

    modport slave (
        input  en, mode, j, k, clr_err,
        output q, qc, chg, sr_err
    );
endinterface

// File: rtl/ff_bank.sv
// Bank of WIDTH independent flip-flops with a shared, runtime-selectable type
// (JK / D / T / SR), per-bit change pulses and a sticky illegal-SR flag.
module ff_bank #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic       clk,
    input  logic       rst_n,
    ff_bank_if.slave   bus
);
    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_D  = 2'b01;
    localparam logic [1:0] MODE_T  = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] chg_r;
    logic             sr_err_r;
    logic [WIDTH-1:0] q_next_s;
    logic             err_set_s;

    // Next-state selection; the mode is used on the edge it is sampled.
    always_comb begin
        q_next_s  = q_r;
        err_set_s = 1'b0;
        if (bus.en) begin
            case (bus.mode)
                MODE_JK: q_next_s = (bus.j & ~q_r) | (~bus.k & q_r);
                MODE_D:  q_next_s = bus.j;
                MODE_T:  q_next_s = q_r ^ bus.j;
                MODE_SR: begin
                    // S=R=1 holds the bit and raises the error flag
                    q_next_s  = (q_r | (bus.j & ~bus.k)) & ~(bus.k & ~bus.j);
                    err_set_s = |(bus.j & bus.k);
                end
                default: q_next_s = q_r;
            endcase
        end else begin
            q_next_s  = q_r;
            err_set_s = 1'b0;
        end
    end

    // State, change-pulse and sticky error registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r      <= RST_VAL;
            chg_r    <= {WIDTH{1'b0}};
            sr_err_r <= 1'b0;
        end else begin
            q_r      <= q_next_s;
            chg_r    <= q_next_s ^ q_r;
            sr_err_r <= err_set_s | (sr_err_r & ~bus.clr_err);
        end
    end

    assign bus.q      = q_r;
    assign bus.qc     = ~q_r;
    assign bus.chg    = chg_r;
    assign bus.sr_err = sr_err_r;
endmodule

// File: tb/tb_ff_bank.sv
// Directed self-checking bench for ff_bank (WIDTH=8/RST_VAL=0 and WIDTH=1/RST_VAL=1).
module tb_ff_bank;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    ff_bank_if #(.WIDTH(8)) b8 ();
    ff_bank_if #(.WIDTH(1)) b1 ();

    ff_bank #(.WIDTH(8), .RST_VAL(8'h00)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    ff_bank #(.WIDTH(1), .RST_VAL(1'b1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic en, input logic [1:0] mode, input logic [7:0] j,
                          input logic [7:0] k, input logic clr);
        b8.en = en; b8.mode = mode; b8.j = j; b8.k = k; b8.clr_err = clr;
    endtask

    initial begin
        rst_n = 1'b0;
        drive8(1'b1, 2'b10, 8'hFF, 8'hFF, 1'b0);
        b1.en = 1'b1; b1.mode = 2'b10; b1.j = 1'b1; b1.k = 1'b0; b1.clr_err = 1'b0;
        step();
        chk("rst_q", b8.q, 64'h00);
        chk("rst_qc", b8.qc, 64'hFF);
        chk("rst_chg", b8.chg, 64'h00);
        chk("rst_err", b8.sr_err, 64'h0);
        chk("w1_rst_q", b1.q, 64'h1);
        chk("w1_rst_qc", b1.qc, 64'h0);
        b1.en = 1'b0;
        rst_n = 1'b1;

        // JK: set/clear then toggle
        drive8(1'b1, 2'b00, 8'hF0, 8'h0F, 1'b0);
        step();
        chk("jk_q", b8.q, 64'hF0);
        chk("jk_qc", b8.qc, 64'h0F);
        chk("jk_chg", b8.chg, 64'hF0);
        drive8(1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0);
        step();
        chk("jk_tog_q", b8.q, 64'h0F);
        chk("jk_tog_chg", b8.chg, 64'hFF);

        // D: clear, then load A5 twice, then switch straight to T
        drive8(1'b1, 2'b01, 8'h00, 8'hFF, 1'b0);
        step();
        chk("d_clr_q", b8.q, 64'h00);
        chk("d_clr_chg", b8.chg, 64'h0F);
        drive8(1'b1, 2'b01, 8'hA5, 8'h3C, 1'b0);
        step();
        chk("d_q1", b8.q, 64'hA5);
        chk("d_chg1", b8.chg, 64'hA5);
        step();
        chk("d_q2", b8.q, 64'hA5);
        chk("d_chg2", b8.chg, 64'h00);
        drive8(1'b1, 2'b10, 8'h81, 8'hFF, 1'b0);
        step();
        chk("t_q", b8.q, 64'h24);
        chk("t_chg", b8.chg, 64'h81);

        // SR: illegal bit0, sticky flag, clear, set-wins, en=0 hold
        drive8(1'b1, 2'b01, 8'h00, 8'h00, 1'b0);
        step();
        chk("d_zero_q", b8.q, 64'h00);
        drive8(1'b1, 2'b11, 8'h03, 8'h01, 1'b0);
        step();
        chk("sr_q", b8.q, 64'h02);
        chk("sr_err_set", b8.sr_err, 64'h1);
        chk("sr_chg", b8.chg, 64'h02);
        drive8(1'b1, 2'b11, 8'h00, 8'h00, 1'b0);
        step();
        chk("sr_err_sticky", b8.sr_err, 64'h1);
        chk("sr_hold_chg", b8.chg, 64'h00);
        drive8(1'b1, 2'b11, 8'h00, 8'h00, 1'b1);
        step();
        chk("sr_err_clr", b8.sr_err, 64'h0);
        drive8(1'b1, 2'b11, 8'h01, 8'h01, 1'b1);
        step();
        chk("sr_set_wins", b8.sr_err, 64'h1);
        chk("sr_set_wins_q", b8.q, 64'h02);
        drive8(1'b0, 2'b11, 8'hFF, 8'hFF, 1'b0);
        step();
        chk("en0_q", b8.q, 64'h02);
        chk("en0_err", b8.sr_err, 64'h1);
        chk("en0_chg", b8.chg, 64'h00);
        drive8(1'b0, 2'b11, 8'hFF, 8'hFF, 1'b1);
        step();
        chk("en0_clr_err", b8.sr_err, 64'h0);

        // Reset mid-operation with a pending T toggle
        drive8(1'b1, 2'b01, 8'h5A, 8'h00, 1'b0);
        step();
        chk("pre_rst_q", b8.q, 64'h5A);
        drive8(1'b1, 2'b11, 8'h01, 8'h01, 1'b0);
        step();
        chk("pre_rst_err", b8.sr_err, 64'h1);
        drive8(1'b1, 2'b10, 8'hFF, 8'h00, 1'b0);
        rst_n = 1'b0;
        step();
        chk("mid_rst_q", b8.q, 64'h00);
        chk("mid_rst_qc", b8.qc, 64'hFF);
        chk("mid_rst_chg", b8.chg, 64'h00);
        chk("mid_rst_err", b8.sr_err, 64'h0);
        rst_n = 1'b1;
        drive8(1'b0, 2'b10, 8'hFF, 8'h00, 1'b0);
        step();
        chk("post_rst_chg", b8.chg, 64'h00);
        chk("post_rst_q", b8.q, 64'h00);

        // rst_n glitch between edges has no effect
        drive8(1'b1, 2'b01, 8'h3C, 8'h00, 1'b0);
        step();
        drive8(1'b0, 2'b01, 8'h00, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        step();
        chk("glitch_q", b8.q, 64'h3C);
        chk("glitch_chg", b8.chg, 64'h00);

        // WIDTH=1, RST_VAL=1 instance in JK mode
        chk("w1_hold_q", b1.q, 64'h1);
        b1.en = 1'b1; b1.mode = 2'b00; b1.j = 1'b0; b1.k = 1'b1;
        step();
        chk("w1_jk_clr_q", b1.q, 64'h0);
        chk("w1_jk_clr_chg", b1.chg, 64'h1);
        b1.j = 1'b1; b1.k = 1'b1;
        step();
        chk("w1_jk_tog_q", b1.q, 64'h1);
        chk("w1_jk_tog_qc", b1.qc, 64'h0);
        b1.en = 1'b0;
        step();
        chk("w1_hold_chg", b1.chg, 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
